// File: rtl/cond_flag_unit.sv
// Program status flags {N,Z,C,V} latched from the ALU, plus one-cycle condition evaluation
// with forwarding from a same-cycle flag update; registered carry feeds back to ALU Cin.
module cond_flag_unit #(
  parameter int          COND_W     = 4,
  parameter logic [3:0]  FLAG_RESET = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_c,
  input  logic              alu_n,
  input  logic              alu_v,
  input  logic              alu_z,
  input  logic              s_bit,
  input  logic              hold,
  input  logic [COND_W-1:0] cond,
  input  logic              cond_req,
  output logic [3:0]        flags,
  output logic              carry_to_alu,
  output logic              cond_true,
  output logic              cond_valid,
  output logic [7:0]        update_count
);

  logic [3:0] flags_q, flags_d;
  logic [7:0] cnt_q, cnt_d;
  logic       true_q, true_d;
  logic       valid_q, valid_d;
  logic [3:0] alu_flags;
  logic [3:0] eff;
  logic       cond_hit;

  assign alu_flags = {alu_n, alu_z, alu_c, alu_v};

  // Forward the executing instruction's flags to the instruction in decode.
  assign eff = (s_bit && !hold) ? alu_flags : flags_q;

  always_comb begin
    cond_hit = 1'b0;
    case (cond)
      4'b0000: cond_hit = eff[2];
      4'b0001: cond_hit = !eff[2];
      4'b0010: cond_hit = eff[1];
      4'b0011: cond_hit = !eff[1];
      4'b0100: cond_hit = eff[3];
      4'b0101: cond_hit = !eff[3];
      4'b0110: cond_hit = eff[0];
      4'b0111: cond_hit = !eff[0];
      4'b1000: cond_hit = eff[1] && !eff[2];
      4'b1001: cond_hit = !eff[1] || eff[2];
      4'b1010: cond_hit = (eff[3] == eff[0]);
      4'b1011: cond_hit = (eff[3] != eff[0]);
      4'b1100: cond_hit = !eff[2] && (eff[3] == eff[0]);
      4'b1101: cond_hit = eff[2] || (eff[3] != eff[0]);
      4'b1110: cond_hit = 1'b1;
      default: cond_hit = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    cnt_d   = cnt_q;
    true_d  = true_q;
    valid_d = valid_q;
    if (!hold) begin
      if (s_bit) begin
        flags_d = alu_flags;
        cnt_d   = cnt_q + 8'd1;
      end
      valid_d = cond_req;
      true_d  = cond_req && cond_hit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= FLAG_RESET;
      cnt_q   <= 8'd0;
      true_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      true_q  <= true_d;
      valid_q <= valid_d;
    end
  end

  assign flags        = flags_q;
  assign carry_to_alu = flags_q[1];
  assign cond_true    = true_q;
  assign cond_valid   = valid_q;
  assign update_count = cnt_q;

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Sits directly downstream of the ALU.
- Latches the ALU condition codes (C, N, V, Z) into a program status flag register when the executing instruction requests a flag update.
- Evaluates the 4-bit instruction condition field against the current flags, with forwarding from a same-cycle update.
- Supplies the registered carry back to the ALU Cin input.

Parameters:
- COND_W, 4, width of instruction condition field.
- FLAG_RESET, 4'b0000, reset value of {N,Z,C,V}.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- alu_c  input  1  ALU carry out.
- alu_n  input  1  ALU negative.
- alu_v  input  1  ALU overflow.
- alu_z  input  1  ALU zero.
- s_bit  input  1  executing instruction updates flags.
- hold  input  1  pipeline stall; freezes all state.
- cond  input  4  condition field of instruction being decoded.
- cond_req  input  1  cond is valid this cycle.
- flags  output  4  registered {N,Z,C,V}.
- carry_to_alu  output  1  registered C, drives ALU Cin.
- cond_true  output  1  registered evaluation result.
- cond_valid  output  1  registered; cond_true is meaningful.
- update_count  output  8  number of flag updates since reset, wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - flags=FLAG_RESET, carry_to_alu=FLAG_RESET[1].
  - cond_true=0, cond_valid=0, update_count=0.
  - Takes effect immediately, mid-operation included.
  - Release is synchronous to the next clk edge.
- Flag register, on rising clk with hold=0:
  - If s_bit=1: flags <= {alu_n,alu_z,alu_c,alu_v} and update_count <= update_count+1 (mod 256, 255 -> 0).
  - If s_bit=0: flags hold their value.
- hold=1 on an edge: flags, update_count, cond_true and cond_valid all hold, regardless of s_bit or cond_req.
- Effective flags:
  - eff = {alu_n,alu_z,alu_c,alu_v} when s_bit=1 and hold=0; otherwise eff = flags.
  - This is the forwarding path: an instruction in decode sees the result of the flag-setting instruction executing in the same cycle.
- Condition evaluation on eff, one cycle latency; on the edge with hold=0, cond_valid <= cond_req and cond_true <= cond_req & f(cond,eff):
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z & (N==V)
  - 1101 LE: Z | (N!=V)
  - 1110 AL: 1
  - 1111 NV: 0
- cond_req=0: cond_valid=0 and cond_true=0 next cycle. cond_true is never 1 without cond_valid.
- carry_to_alu always equals flags[1]. No combinational path from alu_c to carry_to_alu.
- s_bit=1 with X/Z inputs is illegal. cond and cond_req may change every cycle.

Test Plan:
1. Reset:
   - Assert reset=0 mid-cycle after loading flags 4'b1111 -> flags=0000, cond_valid=0, update_count=0 immediately, before any clk edge.
2. Flag latch:
   - alu_{n,z,c,v}=0,1,1,0, s_bit=1 -> next edge flags=0110, carry_to_alu=1, update_count=1.
   - Then s_bit=0 with alu inputs=1111 -> flags stay 0110.
3. Condition sweep:
   - Flags=1001 (N=1,V=1), cond 0..15 with cond_req=1 on successive cycles.
   - Required cond_true sequence: EQ0 NE1 CS0 CC1 MI1 PL0 VS1 VC0 HI0 LS1 GE1 LT0 GT1 LE0 AL1 NV0, each one cycle after its cond.
4. Forwarding:
   - Flags=0000, same cycle s_bit=1 with alu_z=1 and cond=EQ -> next edge cond_true=1 and flags=0100.
   - Without forwarding the result would be 0; the bench must flag 0 as a failure.
5. Hold:
   - Flags=0010, hold=1 with s_bit=1, alu inputs=1101, cond_req=1 for 3 cycles -> flags=0010, cond_valid unchanged, update_count unchanged.
   - Release hold -> normal update on the next edge.
6. Wrap and overflow flags:
   - 256 consecutive s_bit=1 updates -> update_count returns to 0.
   - Feed ALU addition 0x7FFFFFFD+2+2 (V=1, N=1), then cond=GE -> cond_true=1; cond=LT -> cond_true=0.
